// File: rtl/tpu_board_ctrl_if.sv
// Board-side signal bundle between the push-button/LED controller and its environment.
// The controller takes the slave view; the board (or a bench) takes the master view.
interface tpu_board_ctrl_if #(
   parameter int unsigned N_LED = 4
);
   logic             btn_start;
   logic             tpu_done;
   logic             tpu_start;
   logic [N_LED-1:0] led;

   modport master (
      output btn_start,
      output tpu_done,
      input  tpu_start,
      input  led
   );

   modport slave (
      input  btn_start,
      input  tpu_done,
      output tpu_start,
      output led
   );
endinterface

// File: rtl/tpu_board_ctrl.sv
// Push-button start controller for a TPU core: synchronizes and debounces the button,
// issues a one-cycle start pulse, watches for completion or timeout and drives status LEDs.
module tpu_board_ctrl #(
   parameter int unsigned DEBOUNCE_CYC = 1000000,
   parameter int unsigned BLINK_HALF   = 4194304,
   parameter int unsigned BLINK_COUNT  = 6,
   parameter int unsigned TIMEOUT_CYC  = 67108864,
   parameter int unsigned N_LED        = 4
) (
   input logic             clk,
   input logic             srstn,
   tpu_board_ctrl_if.slave bus
);

   localparam int unsigned DbW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int unsigned TmW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned BlW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int unsigned HfW = $clog2(2 * BLINK_COUNT);
   localparam int unsigned RcW = (N_LED > 3) ? N_LED - 3 : 1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StBusy,
      StBlink,
      StError
   } state_e;

   logic [1:0]       sync_q;
   logic             btn_db_q;
   logic [DbW-1:0]   db_cnt_q;
   logic             press_q;

   state_e           state_q, state_d;
   logic [TmW-1:0]   timer_q, timer_d;
   logic [BlW-1:0]   bl_cnt_q, bl_cnt_d;
   logic [HfW-1:0]   half_q, half_d;
   logic [RcW-1:0]   run_cnt_q, run_cnt_d;
   logic [2:0]       led_lo_d;
   logic [N_LED-1:0] led_d;
   logic [N_LED-1:0] led_q;
   logic             tpu_start_q;

   // press_q fires only when the debounced level is accepted as 1, so release is silent.
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         sync_q   <= '0;
         btn_db_q <= 1'b0;
         db_cnt_q <= '0;
         press_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], bus.btn_start};
         press_q <= 1'b0;
         if (sync_q[1] == btn_db_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
            db_cnt_q <= '0;
            btn_db_q <= sync_q[1];
            press_q  <= sync_q[1];
         end else begin
            db_cnt_q <= db_cnt_q + DbW'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bl_cnt_d  = bl_cnt_q;
      half_d    = half_q;
      run_cnt_d = run_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (press_q) state_d = StStart;
         end
         StStart: begin
            timer_d = '0;
            state_d = StBusy;
         end
         StBusy: begin
            // Completion takes priority over a coincident timeout.
            if (bus.tpu_done) begin
               state_d   = StBlink;
               run_cnt_d = run_cnt_q + RcW'(1);
               bl_cnt_d  = '0;
               half_d    = '0;
            end else if (timer_q == TmW'(TIMEOUT_CYC - 1)) begin
               state_d = StError;
            end else begin
               timer_d = timer_q + TmW'(1);
            end
         end
         StBlink: begin
            if (press_q) begin
               state_d = StStart;
            end else if (bl_cnt_q == BlW'(BLINK_HALF - 1)) begin
               bl_cnt_d = '0;
               if (half_q == HfW'(2 * BLINK_COUNT - 1)) state_d = StIdle;
               else half_d = half_q + HfW'(1);
            end else begin
               bl_cnt_d = bl_cnt_q + BlW'(1);
            end
         end
         StError: begin
            if (press_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      led_lo_d    = '0;
      led_lo_d[0] = (state_d == StBusy);
      led_lo_d[1] = (state_d == StBlink) && !half_d[0];
      led_lo_d[2] = (state_d == StError);
   end

   if (N_LED > 3) begin : g_run_leds
      assign led_d = {run_cnt_d, led_lo_d};
   end else begin : g_no_run_leds
      assign led_d = led_lo_d;
   end

   // Outputs are registered from next-state values so they line up with state_q.
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         bl_cnt_q    <= '0;
         half_q      <= '0;
         run_cnt_q   <= '0;
         tpu_start_q <= 1'b0;
         led_q       <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         bl_cnt_q    <= bl_cnt_d;
         half_q      <= half_d;
         run_cnt_q   <= run_cnt_d;
         tpu_start_q <= (state_d == StStart);
         led_q       <= led_d;
      end
   end

   assign bus.tpu_start = tpu_start_q;
   assign bus.led       = led_q;

endmodule

// File: tb/tb_tpu_board_ctrl.sv
// Randomized scenario bench for tpu_board_ctrl with small parameters; expectations come
// from the controller's behavioural rules (latency windows, blink arithmetic, run count).
module tb_tpu_board_ctrl;

   localparam int DEB = 4;
   localparam int BH  = 3;
   localparam int BC  = 2;
   localparam int TO  = 20;
   localparam int NL  = 5;
   localparam int RB  = NL - 3;
   localparam int LAT_MIN = DEB + 3;
   localparam int LAT_MAX = DEB + 5;

   logic clk = 1'b0;
   logic srstn = 1'b0;

   tpu_board_ctrl_if #(.N_LED(NL)) bus ();

   tpu_board_ctrl #(
      .DEBOUNCE_CYC(DEB),
      .BLINK_HALF  (BH),
      .BLINK_COUNT (BC),
      .TIMEOUT_CYC (TO),
      .N_LED       (NL)
   ) dut (
      .clk  (clk),
      .srstn(srstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   vectors = 0;
   int   miscompares = 0;
   int   exp_runs = 0;
   int   hold_left = 0;
   int   start_pulses = 0;
   logic prev_start = 1'b0;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Advance one cycle, release a held button when due, and police tpu_start exclusivity.
   task automatic step();
      @(negedge clk);
      if (hold_left > 0) begin
         hold_left--;
         if (hold_left == 0) bus.btn_start = 1'b0;
      end
      if (bus.tpu_start) begin
         start_pulses++;
         vectors++;
         if (prev_start || bus.led[0] || bus.led[1]) begin
            miscompares++;
            $display("FAIL start_exclusive: prev_start=%0b led=%b, required prev_start=0 led[1:0]=00",
                     prev_start, bus.led);
         end
      end
      prev_start = bus.tpu_start;
   endtask

   task automatic wait_start(input int max_steps, output int lat);
      lat = -1;
      for (int i = 1; i <= max_steps; i++) begin
         step();
         if (bus.tpu_start) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_press(output int lat);
      bus.btn_start = 1'b1;
      hold_left = 10;
      wait_start(16, lat);
   endtask

   // Leaves the bench sampling the first cycle after BUSY.
   task automatic run_busy(input int done_at, output int busy_len);
      busy_len = 0;
      for (int k = 1; k <= TO + 5; k++) begin
         step();
         if (!bus.led[0]) break;
         busy_len = k;
         bus.tpu_done = (k == done_at);
      end
      bus.tpu_done = 1'b0;
   endtask

   task automatic capture_blink(output logic [14:0] pat, output logic side,
                                output logic [RB-1:0] rb);
      pat = '0;
      side = 1'b0;
      rb = bus.led[NL-1:3];
      for (int j = 0; j < 15; j++) begin
         if (j > 0) step();
         pat[j] = bus.led[1];
         if (bus.led[0] || bus.led[2]) side = 1'b1;
      end
   endtask

   function automatic logic [14:0] exp_blink();
      logic [14:0] p;
      p = '0;
      for (int j = 0; j < 15; j++) p[j] = (j < 2 * BC * BH) && ((j / BH) % 2 == 0);
      return p;
   endfunction

   task automatic test_reset_held();
      int lat, blen;
      logic [14:0] pat;
      logic side;
      logic [RB-1:0] rb;
      bus.btn_start = 1'b1;
      bus.tpu_done = 1'b0;
      srstn = 1'b0;
      repeat (4) step();
      vectors++;
      if (bus.led !== '0) begin
         miscompares++;
         $display("FAIL reset_led: got %b, required 0", bus.led);
      end
      vectors++;
      if (bus.tpu_start !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_start: got %b, required 0", bus.tpu_start);
      end
      srstn = 1'b1;
      hold_left = 10;
      wait_start(16, lat);
      vectors++;
      if (lat < LAT_MIN || lat > LAT_MAX) begin
         miscompares++;
         $display("FAIL held_after_reset_latency: got %0d, required %0d..%0d", lat, LAT_MIN, LAT_MAX);
      end
      run_busy(5, blen);
      vectors++;
      if (blen != 5) begin
         miscompares++;
         $display("FAIL held_after_reset_busy: got %0d, required 5", blen);
      end
      capture_blink(pat, side, rb);
      exp_runs = (exp_runs + 1) % (1 << RB);
      vectors++;
      if (pat !== exp_blink() || side || rb !== RB'(exp_runs)) begin
         miscompares++;
         $display("FAIL held_after_reset_blink: pat=%b side=%0b runs=%0d, required pat=%b side=0 runs=%0d",
                  pat, side, rb, exp_blink(), exp_runs);
      end
   endtask

   task automatic test_glitch_press();
      int s0, n, gap, lat, blen;
      logic [14:0] pat;
      logic side;
      logic [RB-1:0] rb;
      s0 = start_pulses;
      n = $urandom_range(2, 4);
      for (int g = 0; g < n; g++) begin
         bus.btn_start = 1'b1;
         step();
         bus.btn_start = 1'b0;
         gap = $urandom_range(1, 3);
         repeat (gap) step();
      end
      repeat (DEB + 4) step();
      vectors++;
      if (start_pulses != s0) begin
         miscompares++;
         $display("FAIL glitch_no_start: got %0d pulses, required 0", start_pulses - s0);
      end
      do_press(lat);
      vectors++;
      if (lat < LAT_MIN || lat > LAT_MAX) begin
         miscompares++;
         $display("FAIL press_latency: got %0d, required %0d..%0d", lat, LAT_MIN, LAT_MAX);
      end
      run_busy(7, blen);
      vectors++;
      if (blen != 7) begin
         miscompares++;
         $display("FAIL busy_len_7: got %0d, required 7", blen);
      end
      capture_blink(pat, side, rb);
      exp_runs = (exp_runs + 1) % (1 << RB);
      vectors++;
      if (pat !== exp_blink() || side || rb !== RB'(exp_runs)) begin
         miscompares++;
         $display("FAIL blink_after_7: pat=%b side=%0b runs=%0d, required pat=%b side=0 runs=%0d",
                  pat, side, rb, exp_blink(), exp_runs);
      end
      vectors++;
      if (start_pulses != s0 + 1) begin
         miscompares++;
         $display("FAIL single_start: got %0d pulses, required 1", start_pulses - s0);
      end
   endtask

   task automatic test_timeout();
      int lat, blen, s0, cleared;
      logic bad;
      do_press(lat);
      run_busy(0, blen);
      vectors++;
      if (blen != TO) begin
         miscompares++;
         $display("FAIL timeout_busy_len: got %0d, required %0d", blen, TO);
      end
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         if (bus.led[2] !== 1'b1 || bus.led[1:0] !== 2'b00 || bus.led[NL-1:3] !== RB'(exp_runs))
            bad = 1'b1;
         bus.tpu_done = 1'($urandom_range(0, 1));
      end
      bus.tpu_done = 1'b0;
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL error_steady: led=%b, required led[2:0]=100 runs=%0d", bus.led, exp_runs);
      end
      s0 = start_pulses;
      bus.btn_start = 1'b1;
      hold_left = 10;
      cleared = -1;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (!bus.led[2]) begin
            cleared = i;
            break;
         end
      end
      vectors++;
      if (cleared < LAT_MIN || cleared > LAT_MAX) begin
         miscompares++;
         $display("FAIL error_clear_latency: got %0d, required %0d..%0d", cleared, LAT_MIN, LAT_MAX);
      end
      repeat (12) step();
      vectors++;
      if (start_pulses != s0 || bus.led !== {RB'(exp_runs), 3'b000}) begin
         miscompares++;
         $display("FAIL error_exit_idle: pulses=%0d led=%b, required pulses=0 led=%b",
                  start_pulses - s0, bus.led, {RB'(exp_runs), 3'b000});
      end
   endtask

   task automatic test_done_at_limit();
      int lat, blen;
      logic [14:0] pat;
      logic side;
      logic [RB-1:0] rb;
      do_press(lat);
      run_busy(TO, blen);
      vectors++;
      if (blen != TO) begin
         miscompares++;
         $display("FAIL limit_busy_len: got %0d, required %0d", blen, TO);
      end
      capture_blink(pat, side, rb);
      exp_runs = (exp_runs + 1) % (1 << RB);
      vectors++;
      if (pat !== exp_blink() || side || rb !== RB'(exp_runs)) begin
         miscompares++;
         $display("FAIL limit_done_wins: pat=%b side=%0b runs=%0d, required pat=%b side=0 runs=%0d",
                  pat, side, rb, exp_blink(), exp_runs);
      end
   endtask

   task automatic test_back_to_back();
      int lat, blen, d1, d2;
      logic [14:0] pat;
      logic side;
      logic [RB-1:0] rb;
      d1 = $urandom_range(10, 15);
      do_press(lat);
      run_busy(d1, blen);
      exp_runs = (exp_runs + 1) % (1 << RB);
      vectors++;
      if (blen != d1 || bus.led[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first_run: busy=%0d led1=%b, required busy=%0d led1=1", blen, bus.led[1], d1);
      end
      do_press(lat);
      vectors++;
      if (lat < LAT_MIN || lat > LAT_MAX || bus.led !== {RB'(exp_runs), 3'b000}) begin
         miscompares++;
         $display("FAIL b2b_abort: lat=%0d led=%b, required lat %0d..%0d led=%b",
                  lat, bus.led, LAT_MIN, LAT_MAX, {RB'(exp_runs), 3'b000});
      end
      d2 = $urandom_range(10, TO);
      run_busy(d2, blen);
      capture_blink(pat, side, rb);
      exp_runs = (exp_runs + 1) % (1 << RB);
      vectors++;
      if (blen != d2 || pat !== exp_blink() || side || rb !== RB'(exp_runs)) begin
         miscompares++;
         $display("FAIL b2b_second_run: busy=%0d pat=%b runs=%0d, required busy=%0d pat=%b runs=%0d",
                  blen, pat, rb, d2, exp_blink(), exp_runs);
      end
   endtask

   task automatic test_random_runs();
      int lat, blen, d;
      logic [14:0] pat;
      logic side;
      logic [RB-1:0] rb;
      for (int r = 0; r < 5; r++) begin
         d = $urandom_range(1, TO);
         do_press(lat);
         vectors++;
         if (lat < LAT_MIN || lat > LAT_MAX) begin
            miscompares++;
            $display("FAIL run%0d_latency: got %0d, required %0d..%0d", r, lat, LAT_MIN, LAT_MAX);
         end
         run_busy(d, blen);
         capture_blink(pat, side, rb);
         exp_runs = (exp_runs + 1) % (1 << RB);
         vectors++;
         if (blen != d || pat !== exp_blink() || side || rb !== RB'(exp_runs)) begin
            miscompares++;
            $display("FAIL run%0d: busy=%0d pat=%b runs=%0d, required busy=%0d pat=%b runs=%0d",
                     r, blen, pat, rb, d, exp_blink(), exp_runs);
         end
      end
   endtask

   task automatic test_reset_in_blink();
      int lat, blen, s0;
      logic [14:0] pat;
      logic side;
      logic [RB-1:0] rb;
      do_press(lat);
      run_busy($urandom_range(1, TO), blen);
      repeat ($urandom_range(3, 8)) step();
      bus.btn_start = 1'b0;
      hold_left = 0;
      #2;
      srstn = 1'b0;
      #1;
      vectors++;
      if (bus.led !== '0 || bus.tpu_start !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: led=%b start=%b, required led=0 start=0", bus.led, bus.tpu_start);
      end
      exp_runs = 0;
      repeat (2) step();
      srstn = 1'b1;
      s0 = start_pulses;
      repeat (20) step();
      vectors++;
      if (start_pulses != s0 || bus.led !== '0) begin
         miscompares++;
         $display("FAIL post_reset_idle: pulses=%0d led=%b, required pulses=0 led=0",
                  start_pulses - s0, bus.led);
      end
      do_press(lat);
      run_busy($urandom_range(1, TO), blen);
      capture_blink(pat, side, rb);
      exp_runs = (exp_runs + 1) % (1 << RB);
      vectors++;
      if (pat !== exp_blink() || side || rb !== RB'(exp_runs)) begin
         miscompares++;
         $display("FAIL post_reset_run: pat=%b runs=%0d, required pat=%b runs=%0d",
                  pat, rb, exp_blink(), exp_runs);
      end
   endtask

   initial begin
      bus.btn_start = 1'b0;
      bus.tpu_done = 1'b0;
      test_reset_held();
      test_glitch_press();
      test_timeout();
      test_done_at_limit();
      test_back_to_back();
      test_random_runs();
      test_reset_in_blink();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
